// File: rtl/trng_pool_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : trng_pool_core                                                 |
// | Brief   : Entropy pool with generate / reseed / zeroize operations.      |
// |           Define TRNG_RCT_EN to add the repetition-count health test.    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module trng_pool_core #(
    parameter int OUT_W      = 256,
    parameter int SEED_W     = 512,
    parameter int RCT_CUTOFF = 32
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              TRNG_Go,
    input  logic [1:0]        Op_Type,
    input  logic [SEED_W-1:0] data_in,
    input  logic              ent_bit,
    input  logic              ent_valid,
    output logic              TRNG_Done,
    output logic              TRNG_Busy,
    output logic              TRNG_Error,
    output logic [OUT_W-1:0]  data_out
);

    localparam int c_NCHUNK  = SEED_W / OUT_W;
    localparam int c_CNT_MAX = (OUT_W > c_NCHUNK) ? OUT_W : c_NCHUNK;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_GEN_LAST  = c_CNT_W'(OUT_W - 1);
    localparam logic [c_CNT_W-1:0] c_SEED_LAST = c_CNT_W'(c_NCHUNK - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    localparam logic [1:0] c_OP_GEN    = 2'b00;
    localparam logic [1:0] c_OP_RESEED = 2'b10;
    localparam logic [1:0] c_OP_ZERO   = 2'b11;

    generate
        if ((SEED_W % OUT_W) != 0 || SEED_W < OUT_W || RCT_CUTOFF < 2) begin : g_bad_params
            $error("trng_pool_core: invalid parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GEN    = 2'd1,
        RESEED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              r_state;
    logic [1:0]          r_op;
    logic [SEED_W-1:0]   r_seed;
    logic [OUT_W-1:0]    r_pool;
    logic [OUT_W-1:0]    r_data_out;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_done;
    logic                r_busy;
    logic [OUT_W-1:0]    w_pool_shift;
    logic                w_abort;

    assign w_pool_shift = {r_pool[OUT_W-2:0], ent_bit ^ r_pool[OUT_W-1]};

`ifdef TRNG_RCT_EN
    localparam int c_RCT_W = $clog2(RCT_CUTOFF + 1);

    logic [c_RCT_W-1:0] r_rct_cnt;
    logic [c_RCT_W-1:0] w_rct_next;
    logic               r_rct_bit;
    logic               r_error;

    // First sample of a generate (r_cnt == 0) always starts a fresh run.
    always_comb begin
        w_rct_next = c_RCT_W'(1);
        if (r_cnt != '0 && ent_bit == r_rct_bit)
            w_rct_next = r_rct_cnt + c_RCT_W'(1);
        w_abort = (r_state == GEN) && ent_valid && (w_rct_next == c_RCT_W'(RCT_CUTOFF));
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_rct_cnt <= '0;
            r_rct_bit <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            if (r_state == GEN && ent_valid) begin
                r_rct_cnt <= w_rct_next;
                r_rct_bit <= ent_bit;
            end
            r_error <= w_abort;
        end
    end

    assign TRNG_Error = r_error;
`else
    assign w_abort    = 1'b0;
    assign TRNG_Error = 1'b0;
`endif

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_op       <= '0;
            r_seed     <= '0;
            r_pool     <= '0;
            r_data_out <= '0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (TRNG_Go) begin
                        r_op   <= Op_Type;
                        r_seed <= data_in;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                        case (Op_Type)
                            c_OP_GEN:    r_state <= GEN;
                            c_OP_RESEED: r_state <= RESEED;
                            // Zeroize clears now and spends its one busy cycle in RESEED.
                            c_OP_ZERO: begin
                                r_pool     <= '0;
                                r_data_out <= '0;
                                r_state    <= RESEED;
                            end
                            default: begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end
                        endcase
                    end
                end
                GEN: begin
                    if (ent_valid) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                        if (w_abort) begin
                            r_pool  <= '0;
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_pool <= w_pool_shift;
                            if (r_cnt == c_GEN_LAST) begin
                                r_data_out <= w_pool_shift;
                                r_state    <= DONE;
                                r_done     <= 1'b1;
                            end
                        end
                    end
                end
                RESEED: begin
                    if (r_op == c_OP_ZERO) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_pool <= r_pool ^ r_seed[OUT_W-1:0];
                        r_seed <= r_seed >> OUT_W;
                        r_cnt  <= r_cnt + c_CNT_ONE;
                        if (r_cnt == c_SEED_LAST) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign TRNG_Done = r_done;
    assign TRNG_Busy = r_busy;
    assign data_out  = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_trng_pool_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_trng_pool_core                                              |
// | Brief   : Directed self-checking bench for trng_pool_core (8/16/4).      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_trng_pool_core;

    localparam int OUT_W      = 8;
    localparam int SEED_W     = 16;
    localparam int RCT_CUTOFF = 4;

    logic              clk;
    logic              Reset;
    logic              TRNG_Go;
    logic [1:0]        Op_Type;
    logic [SEED_W-1:0] data_in;
    logic              ent_bit;
    logic              ent_valid;
    logic              TRNG_Done;
    logic              TRNG_Busy;
    logic              TRNG_Error;
    logic [OUT_W-1:0]  data_out;

    int n_checks = 0;
    int n_errors = 0;
    int cycles;

    trng_pool_core #(
        .OUT_W      (OUT_W),
        .SEED_W     (SEED_W),
        .RCT_CUTOFF (RCT_CUTOFF)
    ) u_dut (
        .clk        (clk),
        .Reset      (Reset),
        .TRNG_Go    (TRNG_Go),
        .Op_Type    (Op_Type),
        .data_in    (data_in),
        .ent_bit    (ent_bit),
        .ent_valid  (ent_valid),
        .TRNG_Done  (TRNG_Done),
        .TRNG_Busy  (TRNG_Busy),
        .TRNG_Error (TRNG_Error),
        .data_out   (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pulse Go for one edge starting at the current falling edge.
    task automatic go(input logic [1:0] op, input logic [SEED_W-1:0] din);
        TRNG_Go = 1'b1;
        Op_Type = op;
        data_in = din;
        @(negedge clk);
        TRNG_Go = 1'b0;
        Op_Type = 2'b01;
        data_in = 16'hDEAD;
    endtask

    // Cycles from the Go falling edge until Done is seen (bounded).
    task automatic wait_done(output int n);
        n = 1;
        while (!TRNG_Done && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Feed nsamp samples MSB first; gaps[i] inserts an idle cycle before sample i,
    // during which Go is pulsed with a zeroize request that must be ignored.
    task automatic feed(input logic [7:0] bits, input logic [7:0] gaps, input int nsamp);
        for (int i = 7; i >= 8 - nsamp; i--) begin
            if (gaps[i]) begin
                TRNG_Go   = 1'b1;
                Op_Type   = 2'b11;
                data_in   = 16'hFFFF;
                ent_valid = 1'b0;
                ent_bit   = ~bits[i];
                @(negedge clk);
                check("gap_done", TRNG_Done, 1'b0);
            end
            TRNG_Go   = 1'b0;
            ent_valid = 1'b1;
            ent_bit   = bits[i];
            Op_Type   = 2'($urandom);
            data_in   = 16'($urandom);
            @(negedge clk);
            if (i > 8 - nsamp)
                check("early_done", TRNG_Done, 1'b0);
        end
        ent_valid = 1'b0;
        ent_bit   = 1'b0;
        Op_Type   = 2'b01;
    endtask

    task automatic finish_op(input string tag, input logic [7:0] exp_data, input logic exp_err);
        check({tag, "_done"}, TRNG_Done, 1'b1);
        check({tag, "_busy"}, TRNG_Busy, 1'b1);
        check({tag, "_err"}, TRNG_Error, exp_err);
        check({tag, "_data"}, data_out, exp_data);
        @(negedge clk);
        check({tag, "_done_drop"}, TRNG_Done, 1'b0);
        check({tag, "_busy_drop"}, TRNG_Busy, 1'b0);
        check({tag, "_err_drop"}, TRNG_Error, 1'b0);
    endtask

    initial begin
        Reset     = 1'b1;
        TRNG_Go   = 1'b0;
        Op_Type   = 2'b00;
        data_in   = '0;
        ent_bit   = 1'b0;
        ent_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_done", TRNG_Done, 1'b0);
        check("rst_busy", TRNG_Busy, 1'b0);
        check("rst_err", TRNG_Error, 1'b0);
        check("rst_data", data_out, 8'h00);

        // Zeroize on the very first edge after reset release
        Reset = 1'b0;
        go(2'b11, 16'h0000);
        check("zero_busy_early", TRNG_Busy, 1'b1);
        wait_done(cycles);
        check("zero_latency", cycles, 2);
        finish_op("zero", 8'h00, 1'b0);

        // Generate with gaps and ignored Go pulses
        go(2'b00, 16'h5555);
        feed(8'b10110010, 8'b01001001, 8);
        finish_op("gen1", 8'hB2, 1'b0);

        go(2'b01, 16'hFFFF);
        wait_done(cycles);
        check("noop_latency", cycles, 1);
        finish_op("noop", 8'hB2, 1'b0);

        go(2'b10, 16'h1234);
        wait_done(cycles);
        check("reseed_latency", cycles, 3);
        finish_op("reseed", 8'hB2, 1'b0);

`ifdef TRNG_RCT_EN
        // All-zero entropy trips the health test on the 4th sample
        go(2'b00, 16'h0000);
        feed(8'b00000000, 8'b00000000, 4);
        finish_op("gen_zero_abort", 8'hB2, 1'b1);

        go(2'b00, 16'h0000);
        feed(8'b11111111, 8'b00100000, 4);
        finish_op("gen_one_abort", 8'hB2, 1'b1);

        go(2'b00, 16'h0000);
        feed(8'b00000000, 8'b00000000, 4);
        finish_op("gen_zero_abort2", 8'hB2, 1'b1);

        // Runs of RCT_CUTOFF-1 must pass; pool is zero after the abort
        go(2'b00, 16'h0000);
        feed(8'b11100011, 8'b00010000, 8);
        finish_op("gen_runs3", 8'hE3, 1'b0);
`else
        go(2'b00, 16'h0000);
        feed(8'b00000000, 8'b00000000, 8);
        finish_op("gen_zero", 8'h94, 1'b0);

        go(2'b00, 16'h0000);
        feed(8'b11111111, 8'b00100000, 8);
        finish_op("gen_one", 8'h6B, 1'b0);

        go(2'b00, 16'h0000);
        feed(8'b11100011, 8'b00010000, 8);
        finish_op("gen_runs3", 8'h88, 1'b0);
`endif

        // Reset asserted in the middle of a generate
        go(2'b00, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            ent_valid = 1'b1;
            ent_bit   = i[0];
            TRNG_Go   = 1'b1;
            Op_Type   = 2'b11;
            @(negedge clk);
            check("midgen_busy", TRNG_Busy, 1'b1);
            check("midgen_done", TRNG_Done, 1'b0);
        end
        TRNG_Go = 1'b0;
        #2 Reset = 1'b1;
        #1;
        check("arst_data", data_out, 8'h00);
        check("arst_busy", TRNG_Busy, 1'b0);
        check("arst_done", TRNG_Done, 1'b0);
        check("arst_err", TRNG_Error, 1'b0);
        for (int i = 0; i < 3; i++) begin
            ent_bit = ~ent_bit;
            @(negedge clk);
            check("arst_hold_done", TRNG_Done, 1'b0);
            check("arst_hold_busy", TRNG_Busy, 1'b0);
        end
        ent_valid = 1'b0;
        Reset     = 1'b0;
        go(2'b01, 16'h0000);
        wait_done(cycles);
        check("post_rst_noop_latency", cycles, 1);
        finish_op("post_rst_noop", 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks", n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
